// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for the fetch queue: enqueue side, dequeue side, flush and status.
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4
);
    logic                     flush;
    logic                     enq_valid;
    logic                     enq_ready;
    logic [XLEN-1:0]          enq_pc;
    logic [ILEN-1:0]          enq_instr;
    logic                     deq_valid;
    logic                     deq_ready;
    logic [XLEN-1:0]          deq_pc;
    logic [ILEN-1:0]          deq_instr;
    logic [$clog2(DEPTH):0]   count;
    logic                     almost_full;

    modport master (
        output flush, enq_valid, enq_pc, enq_instr, deq_ready,
        input  enq_ready, deq_valid, deq_pc, deq_instr, count, almost_full
    );

    modport slave (
        input  flush, enq_valid, enq_pc, enq_instr, deq_ready,
        output enq_ready, deq_valid, deq_pc, deq_instr, count, almost_full
    );
endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry FWFT {pc, instr} queue between IF and ID; an entry written at edge N shows on deq_* after N.
// enq_ready drops when full (never from deq_ready); flush empties the queue and gates both handshakes.
module fetch_queue #(
    parameter int XLEN        = 32,
    parameter int ILEN        = 32,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = 3
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            enq_fire;
    logic            deq_fire;
    entry_t          head;

    assign bus.enq_ready   = reset & ~bus.flush & (cnt != CW'(DEPTH));
    assign bus.deq_valid   = ~bus.flush & (cnt != '0);
    assign enq_fire        = bus.enq_valid & bus.enq_ready;
    assign deq_fire        = bus.deq_valid & bus.deq_ready;

    assign head            = mem[rd_ptr];
    assign bus.deq_pc      = head.pc;
    assign bus.deq_instr   = head.instr;
    assign bus.count       = cnt;
    assign bus.almost_full = (cnt >= CW'(AFULL_LEVEL));

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[wr_ptr] <= '{pc: bus.enq_pc, instr: bus.enq_instr};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (enq_fire && !deq_fire) begin
                cnt <= cnt + CW'(1);
            end else if (deq_fire && !enq_fire) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Pointer distance matches occupancy modulo DEPTH; equal pointers mean empty or full.
    a_cnt_max:   assert property (@(posedge clk) disable iff (!reset) cnt <= CW'(DEPTH));
    a_cnt_ptrs:  assert property (@(posedge clk) disable iff (!reset) cnt[PW-1:0] == PW'(wr_ptr - rd_ptr));
    a_no_ovf:    assert property (@(posedge clk) disable iff (!reset) !(enq_fire && cnt == CW'(DEPTH)));
    a_no_udf:    assert property (@(posedge clk) disable iff (!reset) !(deq_fire && cnt == '0));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random stimulus for fetch_queue, checked every cycle against a queue-based reference.
module tb_fetch_queue;
    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;
    localparam int AFULL = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;
    ent_t mq[$];

    fetch_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) bus ();

    fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    function automatic void cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: an in-order list of accepted entries, updated with the same edge the DUT sees.
    always @(posedge clk) begin
        bit m_enq;
        bit m_deq;
        m_enq = reset && !bus.flush && bus.enq_valid && (mq.size() < DEPTH);
        m_deq = !bus.flush && bus.deq_ready && (mq.size() != 0);
        if (!reset || bus.flush) begin
            mq.delete();
        end else begin
            if (m_deq) void'(mq.pop_front());
            if (m_enq) mq.push_back('{pc: bus.enq_pc, instr: bus.enq_instr});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_rdy;
            bit exp_vld;
            exp_rdy = reset && !bus.flush && (mq.size() != DEPTH);
            exp_vld = !bus.flush && (mq.size() != 0);
            cmp("enq_ready", 64'(bus.enq_ready), 64'(exp_rdy));
            cmp("deq_valid", 64'(bus.deq_valid), 64'(exp_vld));
            cmp("count", 64'(bus.count), 64'(mq.size()));
            cmp("almost_full", 64'(bus.almost_full), 64'(mq.size() >= AFULL));
            if (exp_vld) begin
                cmp("deq_pc", 64'(bus.deq_pc), 64'(mq[0].pc));
                cmp("deq_instr", 64'(bus.deq_instr), 64'(mq[0].instr));
            end
        end
    end

    // Applies one cycle of inputs just after the rising edge, returns at the following falling edge.
    task automatic cyc(input bit fl, input bit ev, input logic [31:0] pc, input bit dr);
        @(posedge clk);
        #1;
        bus.flush     = fl;
        bus.enq_valid = ev;
        bus.enq_pc    = pc;
        bus.enq_instr = instr_of(pc);
        bus.deq_ready = dr;
        @(negedge clk);
    endtask

    initial begin
        reset         = 1'b0;
        bus.flush     = 1'b0;
        bus.enq_valid = 1'b1;
        bus.enq_pc    = 32'h900;
        bus.enq_instr = instr_of(32'h900);
        bus.deq_ready = 1'b0;

        // Reset held low with fetch presenting
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("rst_count", 64'(bus.count), 64'd0);
        cmp("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
        cmp("rst_enq_ready", 64'(bus.enq_ready), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        bus.enq_valid = 1'b0;
        @(negedge clk);
        cmp("rel_enq_ready", 64'(bus.enq_ready), 64'd1);
        cmp("rel_almost_full", 64'(bus.almost_full), 64'd0);

        // Fill then drain
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'(4 * i), 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cmp("full_count", 64'(bus.count), 64'd4);
        cmp("full_enq_ready", 64'(bus.enq_ready), 64'd0);
        cmp("full_almost_full", 64'(bus.almost_full), 64'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1);
            cmp("drain_pc", 64'(bus.deq_pc), 64'(4 * i));
            cmp("drain_valid", 64'(bus.deq_valid), 64'd1);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cmp("drained_valid", 64'(bus.deq_valid), 64'd0);

        // Streaming through pointer wrap
        cyc(1'b0, 1'b1, 32'h100, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b0, 1'b1, 32'(32'h100 + 4 * k), 1'b1);
            cmp("stream_pc", 64'(bus.deq_pc), 64'(32'h100 + 4 * (k - 1)));
            cmp("stream_count", 64'(bus.count), 64'd1);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cmp("stream_last", 64'(bus.deq_pc), 64'h150);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cmp("stream_empty", 64'(bus.count), 64'd0);

        // Flush with a concurrent enqueue
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'(32'h300 + 4 * i), 1'b0);
        cyc(1'b1, 1'b1, 32'h200, 1'b0);
        cmp("flush_enq_ready", 64'(bus.enq_ready), 64'd0);
        cmp("flush_deq_valid", 64'(bus.deq_valid), 64'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cmp("post_flush_count", 64'(bus.count), 64'd0);
        cmp("post_flush_valid", 64'(bus.deq_valid), 64'd0);
        cyc(1'b0, 1'b1, 32'h204, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cmp("post_flush_head", 64'(bus.deq_pc), 64'h204);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);

        // Full with dequeue: enqueue refused that cycle, accepted the next
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'(32'h400 + 4 * i), 1'b0);
        cyc(1'b0, 1'b1, 32'h410, 1'b1);
        cmp("fd_enq_ready", 64'(bus.enq_ready), 64'd0);
        cmp("fd_head", 64'(bus.deq_pc), 64'h400);
        cyc(1'b0, 1'b1, 32'h410, 1'b0);
        cmp("fd_count3", 64'(bus.count), 64'd3);
        cmp("fd_head2", 64'(bus.deq_pc), 64'h404);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cmp("fd_count4", 64'(bus.count), 64'd4);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cmp("fd_drained", 64'(bus.count), 64'd0);

        // Random traffic with occasional flush and reset
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            reset         = ($urandom_range(0, 199) != 0);
            bus.flush     = ($urandom_range(0, 31) == 0);
            bus.enq_valid = ($urandom_range(0, 3) != 0);
            bus.enq_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            bus.enq_instr = $urandom;
            bus.deq_ready = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.enq_valid = 1'b0;
        bus.deq_ready = 1'b1;
        repeat (DEPTH + 1) @(posedge clk);
        @(negedge clk);
        cmp("final_empty", 64'(bus.count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
